uart_rx_byte: RTL and testbench
===============================

# uart_rx_byte

UART receive front end for the 8N1 link.
- Samples the asynchronous serial line and recovers each 8-bit character.
- Presents each good character as a byte plus a one-cycle write strobe.
- Sits directly upstream of the UART data register: drives that register's second write port (data in + write enable), and the register keeps the last received value.

## Interface
Parameters:
- CLKS_PER_BIT, default 10417, clock cycles per bit (100 MHz / 9600 baud); minimum legal value 4.
- HALF_BIT, default CLKS_PER_BIT/2, offset from start-bit detection to the start-bit sample point.

Ports:
- clk_i  in  1  system clock; only clock domain.
- reset_ni  in  1  asynchronous active-low reset; deassertion synchronous to clk_i.
- rx_i  in  1  serial line; asynchronous; idle high.
- data_o  out  8  last correctly framed byte; LSB received first.
- we_o  out  1  one-cycle strobe, high in the cycle data_o takes a new byte; connects to the register's write enable.
- frame_err_o  out  1  one-cycle strobe on a stop-bit error.
- busy_o  out  1  high whenever the FSM is not in IDLE.

## Operation
- rx_i passes through a 2-flop synchronizer, reset value 1; rx_s is the second stage. Only rx_s is used by the FSM.
- One bit counter (width clog2(CLKS_PER_BIT)), a 3-bit bit index and an 8-bit shift register.
- FSM states are IDLE, START, DATA, STOP, RECOVER.

State transitions:
- IDLE: when rx_s==0, go to START and clear the counter.
- START: at count HALF_BIT-1, sample rx_s.
  - If 1: glitch; return to IDLE with no strobe.
  - If 0: go to DATA with bit index 0 and clear the counter.
- DATA: at count CLKS_PER_BIT-1, shift rx_s into bit[index] (LSB first) and clear the counter.
  - After index 7, go to STOP; otherwise increment the index.
- STOP: at count CLKS_PER_BIT-1, sample rx_s.
  - If 1: load data_o with the shift register, pulse we_o, go to IDLE.
  - If 0: pulse frame_err_o, leave data_o unchanged, go to RECOVER.
- RECOVER: stay until rx_s==1, then go to IDLE. A held break produces exactly one frame_err_o.

Reset values (async, while reset_ni==0):
- state = IDLE
- data_o = 8'h00
- we_o = 0
- frame_err_o = 0
- busy_o = 0
- shift register and counters = 0
- synchronizer = 1

Other rules:
- Reset asserted mid-frame aborts the frame with no strobe. After release, a line already low is treated as a new start bit.
- we_o and frame_err_o are registered and never high in the same cycle.
- Neither strobe is high for more than one cycle per frame.
- data_o holds its value between strobes.

## Timing
- Let F be the clk_i edge that first captures rx_i low. The FSM enters START at edge E0 = F+2.
- Sample points:
  - start bit at E0+HALF_BIT
  - data bit k (k=0..7) at E0+HALF_BIT+(k+1)*CLKS_PER_BIT
  - stop bit at E0+HALF_BIT+9*CLKS_PER_BIT
- we_o or frame_err_o is high for the single cycle after the stop-bit sample edge. data_o is valid in that same cycle.
- The FSM returns to IDLE on the stop-sample edge, half a bit before the line's stop bit ends. It can therefore accept a back-to-back start bit with zero idle time.
- Tolerated baud mismatch is about ±4% (sampling near mid-bit for all 10 bits).
- There is no backpressure: the downstream register must accept we_o in every cycle it is asserted.

## Test plan
Use CLKS_PER_BIT=16, HALF_BIT=8.
- Reset, then idle line for 50 cycles -> data_o=8'h00; we_o, frame_err_o and busy_o stay 0.
- Send 8'hA5 (8N1, 16 clk/bit) -> exactly one we_o pulse 153 cycles after E0; data_o=8'hA5; busy_o high from E0 until the stop sample.
- Send 8'h3C then 8'hC3 back-to-back with no idle -> two we_o pulses 160 cycles apart; data_o reads 8'h3C then 8'hC3; no frame_err_o.
- Low glitch of 4 cycles on an idle line -> FSM returns to IDLE at E0+8; no strobes; data_o unchanged.
- Frame 8'h55 with stop bit forced 0, line then held low 100 cycles -> one frame_err_o pulse, no we_o, data_o keeps the previous value. The next valid frame 8'h0F after the line returns high is received correctly.
- reset_ni pulsed low during data bit 4 of 8'hFF -> outputs go to reset values immediately; no we_o for that frame. A following 8'h81 is received correctly.

Source files
------------

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receive front end.
// Recovers one byte per frame and drives the data register's second write port.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       we_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_END = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RECOVER
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rx_meta;
  logic          r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_we;
  logic          r_ferr;

  logic          w_cnt_clr;
  logic          w_shift;
  logic          w_idx_clr;
  logic          w_we;
  logic          w_ferr;
  logic          w_half;
  logic          w_full;

  assign w_half = (r_cnt == HALF_END);
  assign w_full = (r_cnt == FULL_END);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift     = 1'b0;
    w_idx_clr   = 1'b0;
    w_we        = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_clr   = 1'b1;
        end
      end
      S_START: begin
        if (w_half) begin
          w_cnt_clr = 1'b1;
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_idx_clr   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_full) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_full) begin
          w_cnt_clr = 1'b1;
          if (r_rx_s) begin
            w_we        = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_RECOVER;
          end
        end
      end
      S_RECOVER: begin
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= S_IDLE;
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_cnt     <= '0;
      r_idx     <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_we      <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
      r_state   <= w_state_nxt;
      r_we      <= w_we;
      r_ferr    <= w_ferr;
      // The counter only runs while timing a bit; idle and recovery keep it parked.
      if (w_cnt_clr || r_state == S_IDLE || r_state == S_RECOVER) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_idx_clr) begin
        r_idx <= 3'd0;
      end else if (w_shift) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_shift) begin
        r_shift[r_idx] <= r_rx_s;
      end
      if (w_we) begin
        r_data <= r_shift;
      end
    end
  end

  assign data_o      = r_data;
  assign we_o        = r_we;
  assign frame_err_o = r_ferr;
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - self-checking bench for uart_rx_byte.
// A frame-level scoreboard predicts each strobe's byte and capture edge from the frame start.
module tb_uart_rx_byte;

  localparam int C = 16;
  localparam int H = 8;
  // Edges from the first edge that sees the line low to the edge that captures the strobe.
  localparam int STROBE_LAT = 2 + H + 9 * C + 1;

  logic       clk_i;
  logic       reset_ni;
  logic       rx_i;
  logic [7:0] data_o;
  logic       we_o;
  logic       frame_err_o;
  logic       busy_o;

  typedef struct {
    logic [7:0] d;
    int         e;
  } exp_t;

  exp_t       wq[$];
  int         fq[$];
  int         cyc;
  int         n_checks;
  int         n_fail;
  logic [7:0] last_exp;

  uart_rx_byte #(
    .CLKS_PER_BIT(C),
    .HALF_BIT    (H)
  ) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .we_o       (we_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drives one frame starting at the current falling edge.
  task automatic send_raw(input logic [7:0] b, input logic stop_b, input int extra_low);
    rx_i = 1'b0;
    repeat (C) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (C) @(negedge clk_i);
    end
    rx_i = stop_b;
    repeat (C + extra_low) @(negedge clk_i);
    rx_i = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_t x;
    x.d = b;
    x.e = cyc + 1 + STROBE_LAT;
    wq.push_back(x);
    send_raw(b, 1'b1, 0);
  endtask

  task automatic send_bad(input logic [7:0] b, input int extra_low);
    fq.push_back(cyc + 1 + STROBE_LAT);
    send_raw(b, 1'b0, extra_low);
  endtask

  always @(negedge clk_i) begin
    if (reset_ni) begin
      if (we_o && frame_err_o) check("strobe_excl", 1, 0);
      if (we_o) begin
        if (wq.size() == 0) begin
          check("we_unexpected", 1, 0);
        end else begin
          exp_t x;
          x = wq.pop_front();
          check("we_data", data_o, x.d);
          check("we_edge", cyc + 1, x.e);
          last_exp = x.d;
        end
      end else begin
        check("data_hold", data_o, last_exp);
      end
      if (frame_err_o) begin
        if (fq.size() == 0) check("ferr_unexpected", 1, 0);
        else check("ferr_edge", cyc + 1, fq.pop_front());
      end
    end
  end

  initial begin
    int quiet;
    n_checks = 0;
    n_fail   = 0;
    last_exp = 8'h00;
    rx_i     = 1'b1;
    reset_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_data", data_o, 8'h00);
    check("rst_we", we_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_busy", busy_o, 0);
    reset_ni = 1'b1;

    quiet = 0;
    repeat (50) begin
      @(negedge clk_i);
      if (we_o || frame_err_o || busy_o) quiet++;
    end
    check("idle_quiet", quiet, 0);

    // Single frame with busy window around E0 and the stop sample.
    fork
      send_byte(8'hA5);
      begin
        repeat (2) @(negedge clk_i);
        check("busy_before_e0", busy_o, 0);
        @(negedge clk_i);
        check("busy_at_e0", busy_o, 1);
        repeat (151) @(negedge clk_i);
        check("busy_before_stop", busy_o, 1);
        @(negedge clk_i);
        check("busy_after_stop", busy_o, 0);
      end
    join
    repeat (10) @(negedge clk_i);

    send_byte(8'h3C);
    send_byte(8'hC3);
    repeat (10) @(negedge clk_i);

    // Short low glitch is rejected at the start-bit sample.
    rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (6) @(negedge clk_i);
    check("glitch_busy_e0p7", busy_o, 1);
    @(negedge clk_i);
    check("glitch_busy_e0p8", busy_o, 0);
    repeat (10) @(negedge clk_i);

    send_bad(8'h55, 100);
    repeat (5) @(negedge clk_i);
    check("recover_idle", busy_o, 0);
    send_byte(8'h0F);
    repeat (10) @(negedge clk_i);

    // Reset during data bit 4 of 8'hFF.
    rx_i = 1'b0;
    repeat (C) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (4 * C + 8) @(negedge clk_i);
    #2;
    last_exp = 8'h00;
    reset_ni = 1'b0;
    #1;
    check("midrst_data", data_o, 8'h00);
    check("midrst_we", we_o, 0);
    check("midrst_ferr", frame_err_o, 0);
    check("midrst_busy", busy_o, 0);
    repeat (2) @(negedge clk_i);
    #2;
    reset_ni = 1'b1;
    repeat (30) @(negedge clk_i);
    send_byte(8'h81);

    // Randomized frames with random idle gaps, including zero.
    for (int n = 0; n < 10; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(negedge clk_i);
      if ($urandom_range(0, 4) == 0) begin
        send_bad(b, $urandom_range(0, 40));
        repeat (3) @(negedge clk_i);
      end else begin
        send_byte(b);
      end
    end

    repeat (40) @(negedge clk_i);
    check("we_queue_drained", wq.size(), 0);
    check("ferr_queue_drained", fq.size(), 0);
    check("final_busy", busy_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
